// File: rtl/dmem_sync.sv
// Clocked, handshaked data memory: valid/ready request, fixed BUSY latency, byte-lane stores,
// backpressured response. Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned addresses.
module dmem_sync #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                write_done
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic                err_q, err_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                write_done_q, write_done_d;
   logic                mem_we_c;
   logic                out_of_range_c;
   logic                acc_err_c;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   // Any address bit above the index field also lands here, since the shifted value exceeds DEPTH-1.
   assign out_of_range_c = (req_addr >> OFF_W) >= ADDR_W'(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
   assign acc_err_c = out_of_range_c || ((req_addr & ADDR_W'(BE_W - 1)) != '0);
`else
   assign acc_err_c = out_of_range_c;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      err_d        = err_q;
      req_ready_d  = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      write_done_d = 1'b0;
      mem_we_c     = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               write_d     = req_write;
               idx_d       = IDX_W'(req_addr >> OFF_W);
               wdata_d     = req_wdata;
               be_d        = req_be;
               err_d       = acc_err_c;
               cnt_d       = CNT_W'(WAIT_CYCLES - 1);
               state_d     = BUSY;
               req_ready_d = 1'b0;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               mem_we_c     = write_q && !err_q;
               write_done_d = write_q && !err_q;
               rsp_rdata_d  = (!write_q && !err_q) ? mem_q[idx_q] : '0;
               rsp_err_d    = err_q;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         err_q        <= 1'b0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         write_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         idx_q        <= idx_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         err_q        <= err_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         write_done_q <= write_done_d;
      end
   end

   // Storage array is deliberately not reset; reset forces IDLE so a pending store never commits.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (be_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign write_done = write_done_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench for dmem_sync: two instances (WAIT_CYCLES 1 and 3) sharing request inputs,
// expected responses predicted from a reference array and queued in a scoreboard.
module tb_dmem_sync;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        wd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n1, rst_n3;
   logic        req_valid1, req_valid3;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_ready;
   logic        req_ready1, rsp_valid1, rsp_err1, write_done1;
   logic        req_ready3, rsp_valid3, rsp_err3, write_done3;
   logic [31:0] rsp_rdata1, rsp_rdata3;

   logic        sel;
   logic        o_ready, o_valid, o_err, o_wd;
   logic [31:0] o_rdata;

   logic [31:0] m1 [256];
   logic [31:0] m3 [256];
   exp_t        sb_q [$];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   dmem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
      .rsp_err(rsp_err1), .write_done(write_done1)
   );

   dmem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
      .rsp_err(rsp_err3), .write_done(write_done3)
   );

   always_comb begin
      if (sel) begin
         o_ready = req_ready3; o_valid = rsp_valid3; o_err = rsp_err3;
         o_wd    = write_done3; o_rdata = rsp_rdata3;
      end else begin
         o_ready = req_ready1; o_valid = rsp_valid1; o_err = rsp_err1;
         o_wd    = write_done1; o_rdata = rsp_rdata1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel) req_valid3 = v;
      else     req_valid1 = v;
   endtask

   // Reference model: range (and optional alignment) check, byte-lane merge on stores.
   function automatic exp_t predict(input logic wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be);
      exp_t        e;
      logic [31:0] w;
      int          idx;
      logic        err;
      idx = int'(addr >> 2);
      err = (addr >> 2) >= 32'd256;
`ifdef DMEM_ALIGN_CHECK_EN
      err = err || (addr[1:0] != 2'b00);
`endif
      e.err   = err;
      e.wd    = wr && !err;
      e.rdata = '0;
      if (!err) begin
         w = sel ? m3[idx] : m1[idx];
         if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
            if (sel) m3[idx] = w;
            else     m1[idx] = w;
         end else begin
            e.rdata = w;
         end
      end
      return e;
   endfunction

   task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold);
      exp_t e;
      int   n;
      int   wc;
      wc = sel ? 3 : 1;
      sb_q.push_back(predict(wr, addr, wdata, be));
      @(negedge clk);
      req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = (hold == 0);
      set_valid(1'b1);
      n = 0;
      while (!o_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " req_ready"}, 32'(o_ready), 32'd1);
      @(posedge clk);
      #1;
      set_valid(1'b0);
      req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom); req_write = 1'($urandom);
      repeat (wc) begin
         @(negedge clk);
         chk({tag, " busy no rsp"}, 32'(o_valid), 32'd0);
      end
      @(negedge clk);
      e = sb_q.pop_front();
      chk({tag, " rsp_valid"},  32'(o_valid), 32'd1);
      chk({tag, " rsp_rdata"},  o_rdata, e.rdata);
      chk({tag, " rsp_err"},    32'(o_err), 32'(e.err));
      chk({tag, " write_done"}, 32'(o_wd), 32'(e.wd));
      chk({tag, " ready in resp"}, 32'(o_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         set_valid(1'b1);
         req_write = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
         @(negedge clk);
         chk({tag, " hold valid"}, 32'(o_valid), 32'd1);
         chk({tag, " hold rdata"}, o_rdata, e.rdata);
         chk({tag, " hold ready"}, 32'(o_ready), 32'd0);
         chk({tag, " hold wd"},    32'(o_wd), 32'd0);
      end
      set_valid(1'b0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, " rsp closed"}, 32'(o_valid), 32'd0);
      chk({tag, " idle ready"}, 32'(o_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0;
      rst_n1 = 1'b0; rst_n3 = 1'b0;
      req_valid1 = 1'b0; req_valid3 = 1'b0;
      req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst ready1", 32'(req_ready1), 32'd0);
      chk("rst valid1", 32'(rsp_valid1), 32'd0);
      chk("rst rdata1", rsp_rdata1, 32'd0);
      chk("rst err1",   32'(rsp_err1), 32'd0);
      chk("rst wd1",    32'(write_done1), 32'd0);
      chk("rst ready3", 32'(req_ready3), 32'd0);
      chk("rst valid3", 32'(rsp_valid3), 32'd0);
      rst_n1 = 1'b1; rst_n3 = 1'b1;
      @(negedge clk);
      chk("post-rst ready1", 32'(req_ready1), 32'd1);

      // Basic store then load, single-cycle wait.
      access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      access("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0);
      chk("ld10 literal", m1[4], 32'hDEADBEEF);

      // Partial byte-lane merge and an all-lanes-disabled store.
      access("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
      access("st20be", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
      access("st20be0", 1'b1, 32'h20, 32'h99999999, 4'h0, 0);
      access("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0);
      chk("ld20 literal", m1[8], 32'h11BB33DD);

      // Out-of-range load and store; word 0 must survive.
      access("st0", 1'b1, 32'h0, 32'h55AA55AA, 4'hF, 0);
      access("ld400", 1'b0, 32'h400, 32'h0, 4'h0, 0);
      access("st400", 1'b1, 32'h400, 32'h12345678, 4'hF, 0);
      access("sthigh", 1'b1, 32'h8000_0000, 32'h12345678, 4'hF, 0);
      access("ld0", 1'b0, 32'h0, 32'h0, 4'h0, 0);

      // Response backpressure with ignored request pulses.
      access("ld10hold", 1'b0, 32'h10, 32'h0, 4'h0, 5);
      access("ld20after", 1'b0, 32'h20, 32'h0, 4'h0, 0);

      // Misaligned load: error with alignment checking, else word 4.
      access("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 0);

      // Longer latency instance, then reset during BUSY discards the store.
      sel = 1'b1;
      access("w3 st30", 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0);
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADBEEF; req_be = 4'hF; rsp_ready = 1'b1;
      chk("rst-mid ready", 32'(o_ready), 32'd1);
      set_valid(1'b1);
      @(posedge clk);
      #1;
      set_valid(1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n3 = 1'b0;
      #1;
      chk("rst-mid ready0", 32'(o_ready), 32'd0);
      chk("rst-mid valid0", 32'(o_valid), 32'd0);
      chk("rst-mid wd0",    32'(o_wd), 32'd0);
      chk("rst-mid rdata0", o_rdata, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("rst-mid no commit", 32'(o_wd), 32'd0);
      end
      rst_n3 = 1'b1;
      @(negedge clk);
      chk("rst-mid release ready", 32'(o_ready), 32'd1);
      access("w3 ld30", 1'b0, 32'h30, 32'h0, 4'h0, 0);
      access("w3 st34be", 1'b1, 32'h34, 32'h01020304, 4'b1000, 0);
      access("w3 hold", 1'b0, 32'h30, 32'h0, 4'h0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
